// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration helpers for the serial subtractor slice.
package serial_sub_pkg;

  // Controller states; the encoding is exported through the bus for checkers.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sersub_state_e;

  // True when the digit size evenly divides the operand width.
  function automatic bit digit_ok(input int width, input int digit);
    return (digit > 0) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// Optional signed-overflow flag is present only with SERSUB_SIGNED_OVF_EN.
//
// Handshake: the master raises start with a/b/bin valid; the request is taken
// on any rising edge where the slave is IDLE or DONE (start is ignored, not
// queued, while busy). busy is high for the N cycles of computation, then done
// pulses for exactly one cycle with diff/bout(/ovf) valid. Holding start high
// through DONE issues the next request on the same edge done falls.
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  import serial_sub_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERSUB_SIGNED_OVF_EN
  logic             ovf;
`endif
  sersub_state_e    state;

`ifdef SERSUB_SIGNED_OVF_EN
  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf, state);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf, state);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout, state);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, state);
`endif

endinterface

// File: rtl/serial_subtractor_digit.sv
// sub_digit: combinational DIGIT-bit ripple of full-subtractor cells.
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  logic [DIGIT:0] brw;

  assign brw[0] = bin;

  // One full-subtractor cell per bit; borrow ripples from LSB to MSB.
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign diff[i]    = a[i] ^ b[i] ^ brw[i];
    assign brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bout = brw[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: diff = a - b - bin computed DIGIT bits per clock.
// Define SERSUB_SIGNED_OVF_EN to add the registered signed-overflow flag.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be at least 2");
  end
  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  sersub_state_e    state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             brw;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic [DIGIT-1:0] slice_diff;
  logic             slice_bout;
  logic [WIDTH-1:0] part_next;
`ifdef SERSUB_SIGNED_OVF_EN
  logic             sign_a;
  logic             sign_b;
  logic             ovf_q;
`endif

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (opa[DIGIT-1:0]),
    .b    (opb[DIGIT-1:0]),
    .bin  (brw),
    .diff (slice_diff),
    .bout (slice_bout)
  );

  // New digit enters the partial result from the MSB side; oldest falls toward bit 0.
  assign part_next = WIDTH'({slice_diff, part} >> DIGIT);

  // Controller, datapath shift registers and result registers in one process.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      brw    <= 1'b0;
      part   <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          opa  <= opa >> DIGIT;
          opb  <= opb >> DIGIT;
          brw  <= slice_bout;
          part <= part_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            diff_q <= part_next;
            bout_q <= slice_bout;
`ifdef SERSUB_SIGNED_OVF_EN
            ovf_q  <= (sign_a != sign_b) && (part_next[WIDTH-1] != sign_a);
`endif
          end
        end
        default: begin
          // IDLE and DONE both accept a request; DONE lasts a single cycle.
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            opa    <= bus.a;
            opb    <= bus.b;
            brw    <= bus.bin;
            cnt    <= '0;
            part   <= '0;
`ifdef SERSUB_SIGNED_OVF_EN
            sign_a <= bus.a[WIDTH-1];
            sign_b <= bus.b[WIDTH-1];
`endif
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign bus.state = state;
`ifdef SERSUB_SIGNED_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (16/1, 4/1, 16/4) checked
// against an arithmetic reference. Honours SERSUB_SIGNED_OVF_EN when defined.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];  // {bout, diff}

  serial_subtractor_if #(.WIDTH(16)) if16 ();
  serial_subtractor_if #(.WIDTH(4))  if4 ();
  serial_subtractor_if #(.WIDTH(16)) ifd4 ();

  serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_w16d1 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  serial_subtractor #(.WIDTH(4),  .DIGIT(1)) u_w4d1  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_w16d4 (.clk(clk), .rst_n(rst_n), .bus(ifd4.slave));

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction; borrow iff the true result is negative.
  function automatic logic [16:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic bin);
    longint d;
    logic [15:0] mask;
    d = longint'(a) - longint'(b) - longint'(bin);
    mask = (w == 16) ? 16'hFFFF : 16'h000F;
    return {(d < 0), 16'(d) & mask};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input int sel, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic bin);
    case (sel)
      0: begin if16.start = st; if16.a = a; if16.b = b; if16.bin = bin; end
      1: begin if4.start = st; if4.a = a[3:0]; if4.b = b[3:0]; if4.bin = bin; end
      default: begin ifd4.start = st; ifd4.a = a; ifd4.b = b; ifd4.bin = bin; end
    endcase
  endtask

  task automatic sample(input int sel, output logic dn, output logic bs, output logic [15:0] d,
                        output logic bo, output logic ov);
    ov = 1'b0;
    case (sel)
      0: begin
        dn = if16.done; bs = if16.busy; d = if16.diff; bo = if16.bout;
`ifdef SERSUB_SIGNED_OVF_EN
        ov = if16.ovf;
`endif
      end
      1: begin
        dn = if4.done; bs = if4.busy; d = {12'h000, if4.diff}; bo = if4.bout;
      end
      default: begin
        dn = ifd4.done; bs = ifd4.busy; d = ifd4.diff; bo = ifd4.bout;
`ifdef SERSUB_SIGNED_OVF_EN
        ov = ifd4.ovf;
`endif
      end
    endcase
  endtask

  // One operation; latency counted in negedges after the start-driving negedge.
  // With poke set, a bogus start is pulsed while the unit is running.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input int exp_lat, input bit poke, input string tag);
    logic [16:0] e;
    logic dn, bs, bo, ov;
    logic [15:0] d;
    int k;
    exp_q.push_back(model((sel == 1) ? 4 : 16, a, b, bin));
    @(negedge clk);
    drive(sel, 1'b1, a, b, bin);
    k = 0;
    dn = 1'b0;
    bs = 1'b0;
    d = '0; bo = 1'b0; ov = 1'b0;
    while (!dn && k < 64) begin
      @(negedge clk);
      k++;
      sample(sel, dn, bs, d, bo, ov);
      if (k == 1) begin
        check({tag, "_busy"}, 32'(bs), 32'd1);
        drive(sel, 1'b0, a, b, bin);
      end
      if (poke && k == 2) drive(sel, 1'b1, ~a, ~b, ~bin);
      if (poke && k == 3) drive(sel, 1'b0, a, b, bin);
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_busy_at_done"}, 32'(bs), 32'd0);
    e = exp_q.pop_front();
    check({tag, "_diff"}, 32'(d), 32'(e[15:0]));
    check({tag, "_bout"}, 32'(bo), 32'(e[16]));
`ifdef SERSUB_SIGNED_OVF_EN
    if (sel != 1) check({tag, "_ovf"}, 32'(ov), 32'((a[15] != b[15]) && (e[15] != a[15])));
`endif
    @(negedge clk);
    sample(sel, dn, bs, d, bo, ov);
    check({tag, "_done_pulse"}, 32'(dn), 32'd0);
  endtask

  // Confirms nothing starts on its own (e.g. a start seen during RUN was not queued).
  task automatic idle_watch(input int sel, input int cycles, input string tag);
    logic dn, bs, bo, ov;
    logic [15:0] d;
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      sample(sel, dn, bs, d, bo, ov);
      if (dn || bs) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic dn, bs, bo, ov;
    logic [15:0] d;
    logic [16:0] e;
    logic [8:0] combo;
    int k;
    int hits;
    logic [15:0] ra, rb;

    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    drive(2, 1'b0, '0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    sample(0, dn, bs, d, bo, ov);
    check("rst_diff", 32'(d), 32'd0);
    check("rst_bout", 32'(bo), 32'd0);
    check("rst_busy", 32'(bs), 32'd0);
    check("rst_done", 32'(dn), 32'd0);
    check("rst_state", 32'(if16.state), 32'(IDLE));
    sample(2, dn, bs, d, bo, ov);
    check("rst_d4_busy", 32'(bs), 32'd0);
    rst_n = 1'b1;

    // Directed cases, WIDTH=16 DIGIT=1
    run_op(0, 16'h0005, 16'h0003, 1'b0, 17, 1'b0, "d1_5m3");
    run_op(0, 16'h0000, 16'h0001, 1'b0, 17, 1'b0, "d1_0m1");
    run_op(0, 16'h8000, 16'h8000, 1'b1, 17, 1'b0, "d1_eq_bin");
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 17, 1'b0, "d1_max_max");
    run_op(0, 16'h8000, 16'h0001, 1'b0, 17, 1'b1, "d1_ovf_poke");

    // WIDTH=16 DIGIT=4, with a start pulsed mid-run
    run_op(2, 16'h1234, 16'h0235, 1'b0, 5, 1'b1, "d4_poke");
    idle_watch(2, 8, "d4_noqueue");

    // Random operands on both 16-bit instances
    for (int i = 0; i < 15; i++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      run_op(0, ra, rb, 1'($urandom_range(0, 1)), 17, 1'($urandom_range(0, 1)), "rnd_d1");
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      run_op(2, ra, rb, 1'($urandom_range(0, 1)), 5, 1'($urandom_range(0, 1)), "rnd_d4");
    end

    // Exhaustive WIDTH=4 sweep with start held high (back-to-back)
    combo = '0;
    exp_q.push_back(model(4, {12'h0, combo[8:5]}, {12'h0, combo[4:1]}, combo[0]));
    @(negedge clk);
    drive(1, 1'b1, {12'h0, combo[8:5]}, {12'h0, combo[4:1]}, combo[0]);
    for (int i = 0; i < 512; i++) begin
      k = 0;
      dn = 1'b0;
      while (!dn && k < 32) begin
        @(negedge clk);
        k++;
        sample(1, dn, bs, d, bo, ov);
      end
      check("sweep_lat", 32'(k), 32'd5);
      e = exp_q.pop_front();
      check("sweep_diff", 32'(d), 32'(e[15:0]));
      check("sweep_bout", 32'(bo), 32'(e[16]));
      if (i < 511) begin
        combo = 9'(i + 1);
        exp_q.push_back(model(4, {12'h0, combo[8:5]}, {12'h0, combo[4:1]}, combo[0]));
        drive(1, 1'b1, {12'h0, combo[8:5]}, {12'h0, combo[4:1]}, combo[0]);
      end else begin
        drive(1, 1'b0, '0, '0, 1'b0);
      end
    end
    idle_watch(1, 6, "sweep_stop");

    // Reset in the middle of a run
    run_op(0, 16'h0000, 16'h0001, 1'b0, 17, 1'b0, "pre_rst");
    @(negedge clk);
    drive(0, 1'b1, 16'h1234, 16'h0034, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h1234, 16'h0034, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sample(0, dn, bs, d, bo, ov);
    check("midrst_diff", 32'(d), 32'd0);
    check("midrst_bout", 32'(bo), 32'd0);
    check("midrst_busy", 32'(bs), 32'd0);
    check("midrst_done", 32'(dn), 32'd0);
    check("midrst_state", 32'(if16.state), 32'(IDLE));
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sample(0, dn, bs, d, bo, ov);
      if (dn) hits++;
    end
    check("midrst_no_done", 32'(hits), 32'd0);
    run_op(0, 16'h0007, 16'h0002, 1'b0, 17, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle, parametrised subtractor that computes `diff = a - b - bin` over WIDTH-bit operands, DIGIT bits per clock, with a start/done handshake. It is the sequential successor to the single-bit full-subtractor cell. It serves area-constrained datapaths where a full-width ripple subtractor is too large, and it produces an unsigned borrow-out plus an optional signed-overflow flag.

## Interface
- `WIDTH`, 16: operand and result width in bits; must be ≥ 2.
- `DIGIT`, 1: bits processed per RUN cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails with `$error`.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: request; sampled only when state is IDLE or DONE.
- `a` input WIDTH: minuend; latched on an accepted start.
- `b` input WIDTH: subtrahend; latched on an accepted start.
- `bin` input 1: borrow-in; latched on an accepted start.
- `busy` output 1: high while state is RUN.
- `done` output 1: one-cycle pulse, high while state is DONE.
- `diff` output WIDTH: result register; holds the last completed result.
- `bout` output 1: final borrow; equals 1 iff a < b + bin, treated as unsigned.
- `ovf` output 1: signed overflow; present only with `SERSUB_SIGNED_OVF_EN`.

## Operation
- States:
  - IDLE: waiting.
  - RUN: one DIGIT slice per cycle.
  - DONE: result valid pulse.
- Define N = WIDTH/DIGIT and digit counter width `$clog2(N)` (minimum 1).
- Transitions:
  - IDLE → RUN on start.
  - RUN → DONE after the N-th digit.
  - DONE → RUN on start, allowing back-to-back operation.
  - DONE → IDLE otherwise.
- Accepted start:
  - latch a and b into operand shift registers;
  - latch bin into the borrow flop;
  - clear the counter and the partial result.
- RUN cycle:
  - the low DIGIT bits of each operand plus the borrow flop feed the digit slice;
  - the slice's DIGIT difference bits shift into the partial register from the MSB side;
  - the operands shift right by DIGIT;
  - the borrow flop takes the slice's borrow-out;
  - the counter increments.
- At the RUN → DONE edge, load `diff`, `bout` and `ovf` from the partial register and final borrow. These outputs do not change at any other time; intermediate digits are never visible.
- `start` while in RUN is ignored and not queued.
- Operand inputs are don't-care except at the accepting edge.

## Timing
- Reset (rst_n low at an edge):
  - state IDLE;
  - busy = 0, done = 0;
  - diff = 0, bout = 0, ovf = 0;
  - counter, operand and borrow registers = 0.
- Reset asserted mid-RUN aborts the operation with no done pulse. It takes priority over start.
- Latency, with start accepted at edge E0:
  - busy is high for cycles E0..E(N-1);
  - the result is registered at edge EN;
  - done is high for exactly the cycle after EN.
- In short, done rises N+1 edges after the start edge, counting from E0 through the DONE edge.
- Throughput: with start held high during DONE, a new operation is accepted on the same edge done falls. The throughput is then one result per N+1 cycles.
- `done` and `busy` are never high together.
- Wrap-around:
  - 0 − 1 gives all-ones with bout = 1;
  - maximum − maximum − 1 gives all-ones with bout = 1.

## Configuration
- `SERSUB_SIGNED_OVF_EN` defined:
  - `ovf` port exists;
  - ovf = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]), computed from the latched operands;
  - ovf is registered with diff.
- Macro undefined:
  - the port and its logic are absent;
  - the sign-bit capture flops are removed.

## Structure
- Package `serial_sub_pkg` holds:
  - state enum `sersub_state_e` {IDLE, RUN, DONE};
  - a localparam function that checks WIDTH/DIGIT divisibility.
- Sub-module `sub_digit #(DIGIT)`: a combinational DIGIT-bit ripple of full-subtractor cells, with ports a, b, bin, diff, bout. The top instantiates it once.
- The top contains the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=16, DIGIT=1: a=0x0005, b=0x0003, bin=0 → diff=0x0002, bout=0. done is high only on the 17th cycle after the start edge.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1. Also a=b=0x8000, bin=1 → diff=0xFFFF, bout=1.
- WIDTH=4, DIGIT=1, exhaustive sweep of all 512 {a,b,bin} combinations using back-to-back starts:
  - diff = (a−b−bin) mod 16;
  - bout matches a<b+bin;
  - one result every 5 cycles.
- WIDTH=16, DIGIT=4:
  - a=0x1234, b=0x0235 → diff=0x0FFF, bout=0, with done 5 cycles after start;
  - a start pulsed during RUN changes nothing.
- Reset mid-RUN:
  - rst_n low at cycle 3 of a run → outputs are 0 and there is no done pulse;
  - the following start with a=7, b=2 → diff=5.
- With `SERSUB_SIGNED_OVF_EN`, WIDTH=16:
  - a=0x8000, b=0x0001 → diff=0x7FFF, ovf=1;
  - a=0x0005, b=0x0003 → ovf=0.
